// File: rtl/des_key_pkg.sv
// rtl/des_key_pkg.sv - shared DES key-path constants, tables, state enum and rotate helpers
package des_key_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int PC1_W    = 2 * CD_W;
  localparam int SUBKEY_W = 48;

  localparam logic [3:0] ROUND_LAST = 4'd15;

  typedef enum logic {IDLE, RUN} state_e;

  // Table entries are 1-based source bit numbers, bit 1 = MSB of the source word.
  localparam int PC1_TAB [PC1_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Shift amount that produces K(i+1) from the previous C/D pair, encrypt order.
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
  endfunction

endpackage

// File: rtl/des_key_sched_iter_if.sv
// rtl/des_key_sched_iter_if.sv - start/load and subkey pull handshake bundle
interface des_key_sched_iter_if import des_key_pkg::*; ();
  logic                start;
  logic [KEY_W-1:0]    key_in;
  logic                decrypt;
  logic                busy;
  logic                key_valid;
  logic                key_ready;
  logic [SUBKEY_W-1:0] subkey;
  logic [3:0]          round;
  logic                last;

  modport master (
    output start, key_in, decrypt, key_ready,
    input  busy, key_valid, subkey, round, last
  );

  modport slave (
    input  start, key_in, decrypt, key_ready,
    output busy, key_valid, subkey, round, last
  );
endinterface

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - DES permuted choice 2, 56-bit C||D to 48-bit round subkey
module des_pc2 import des_key_pkg::*; (
  input  logic [PC1_W-1:0]    cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  for (genvar j = 0; j < SUBKEY_W; j++) begin : g_pc2
    localparam int SRC = PC1_W - PC2_TAB[j];
    assign subkey_o[SUBKEY_W-1-j] = cd_i[SRC];
  end

  // C/D positions 9,18,22,25,35,38,43,54 are dropped by PC2.
  logic unused_dropped;
  assign unused_dropped = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                            cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/key_pc1.sv
// rtl/key_pc1.sv - DES permuted choice 1, 64-bit key to 56-bit C||D
module key_pc1 import des_key_pkg::*; (
  input  logic [KEY_W-1:0] key_i,
  output logic [PC1_W-1:0] pc1_o
);

  for (genvar i = 0; i < PC1_W; i++) begin : g_pc1
    localparam int SRC = KEY_W - PC1_TAB[i];
    assign pc1_o[PC1_W-1-i] = key_i[SRC];
  end

  // Parity bits never reach the schedule.
  logic unused_parity;
  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8],  key_i[0]};

endmodule

// File: rtl/key_split_28.sv
// rtl/key_split_28.sv - splits the PC1 result into the C and D halves
module key_split_28 import des_key_pkg::*; (
  input  logic [PC1_W-1:0] cd_i,
  output logic [CD_W-1:0]  c_o,
  output logic [CD_W-1:0]  d_o
);

  assign c_o = cd_i[PC1_W-1:CD_W];
  assign d_o = cd_i[CD_W-1:0];

endmodule

// File: rtl/des_key_sched_iter.sv
// rtl/des_key_sched_iter.sv - iterative DES key scheduler, one subkey per valid/ready handshake
module des_key_sched_iter import des_key_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  des_key_sched_iter_if.slave  bus
);

  logic [PC1_W-1:0]    pc1_w;
  logic [CD_W-1:0]     c_ld, d_ld;
  logic [SUBKEY_W-1:0] pc2_w;

  key_pc1      u_pc1   (.key_i(bus.key_in), .pc1_o(pc1_w));
  key_split_28 u_split (.cd_i(pc1_w), .c_o(c_ld), .d_o(d_ld));

  state_e          state_q, state_d;
  logic [CD_W-1:0] c_q, c_d, d_q, d_d;
  logic [3:0]      round_q, round_d;
  logic            dec_q, dec_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            accept;
  logic [1:0]      shamt;

  assign accept = valid_q & bus.key_ready;

  // Decrypt walks the encrypt table backwards with right rotations.
  assign shamt = dec_q ? SHIFT_TAB[ROUND_LAST - round_q] : SHIFT_TAB[round_q + 4'd1];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          dec_d   = bus.decrypt;
          round_d = '0;
          // C16/D16 equal C0/D0, so decrypt loads unrotated to present K16 first.
          c_d     = bus.decrypt ? c_ld : rotl28(c_ld, SHIFT_TAB[0]);
          d_d     = bus.decrypt ? d_ld : rotl28(d_ld, SHIFT_TAB[0]);
        end
      end
      RUN: begin
        if (accept) begin
          if (round_q == ROUND_LAST) begin
            state_d = IDLE;
            c_d     = '0;
            d_d     = '0;
            round_d = '0;
            dec_d   = 1'b0;
          end else begin
            round_d = round_q + 4'd1;
            c_d     = dec_q ? rotr28(c_q, shamt) : rotl28(c_q, shamt);
            d_d     = dec_q ? rotr28(d_q, shamt) : rotl28(d_q, shamt);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == RUN);
    valid_d = (state_d == RUN);
    last_d  = (state_d == RUN) && (round_d == ROUND_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  des_pc2 u_pc2 (.cd_i({c_q, d_q}), .subkey_o(pc2_w));

  assign bus.subkey    = valid_q ? pc2_w : '0;
  assign bus.busy      = busy_q;
  assign bus.key_valid = valid_q;
  assign bus.round     = round_q;
  assign bus.last      = last_q;

endmodule
